// File: rtl/piano_voice_select_if.sv
// piano_voice_select_if
//   Bundles the key/note inputs and the voice outputs of piano_voice_select.
//   Ports (signals):
//     keys       - raw asynchronous push buttons, bit i = note i
//     note_in    - per-note square waves, synchronous to clk
//     speaker    - registered audio output
//     busy       - voice FSM is not idle
//     active_key - index of the note sounding or sustaining
//     key_state  - debounced key levels
//   Modports: master (stimulus side), slave (piano_voice_select).
interface piano_voice_select_if #(
  parameter int NUM_KEYS = 8
);
  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] note_in;
  logic                speaker;
  logic                busy;
  logic [KEY_W-1:0]    active_key;
  logic [NUM_KEYS-1:0] key_state;

  modport master (
    output keys, note_in,
    input  speaker, busy, active_key, key_state
  );

  modport slave (
    input  keys, note_in,
    output speaker, busy, active_key, key_state
  );
endinterface

// File: rtl/piano_voice_select.sv
// piano_voice_select
//   Synchronises and debounces the piano keys, picks one sounding key
//   (lowest index wins, held until released) and routes that note's
//   square wave to a registered speaker pin, with an optional sustain
//   tail after release.
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high
//     bus   - piano_voice_select_if.slave (keys, note_in in;
//             speaker, busy, active_key, key_state out)
module piano_voice_select #(
  parameter int NUM_KEYS       = 8,
  parameter int DEB_CYCLES     = 1000000,
  parameter int SUSTAIN_CYCLES = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  piano_voice_select_if.slave   bus
);

  localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [SUS_W-1:0] SUS_LAST =
    SUS_W'((SUSTAIN_CYCLES > 0) ? SUSTAIN_CYCLES - 1 : 0);
  localparam bit HAS_SUSTAIN = (SUSTAIN_CYCLES > 0);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PLAY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // ---------------------------------------------------------------
  // Two-flop synchroniser and per-key debounce
  // ---------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] key_state;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours (sync1 -> sync2 shift).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      key_state <= '0;
      // NOTE: deb_cnt is a small flop array, not RAM, so it can and must
      // be reset so held keys re-debounce from zero after reset.
      for (int i = 0; i < NUM_KEYS; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= bus.keys;
      sync2 <= sync1;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (sync2[i] == key_state[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          // DEB_CYCLES consecutive differing samples: accept the change.
          key_state[i] <= sync2[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Voice FSM
  // ---------------------------------------------------------------
  function automatic logic [KEY_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  logic [1:0]       state, state_nxt;
  logic [KEY_W-1:0] active_key, key_nxt;
  logic [SUS_W-1:0] sus_cnt, sus_nxt;
  logic             busy;
  logic             speaker;
  logic             any_key;

  assign any_key = |key_state;

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    key_nxt   = active_key;
    sus_nxt   = sus_cnt;
    case (state)
      IDLE: begin
        if (any_key) begin
          state_nxt = PLAY;
          key_nxt   = lowest_set(key_state);
        end
      end
      PLAY: begin
        if (!key_state[active_key]) begin
          // The active bit is already 0, so any set bit is another key.
          if (any_key) begin
            key_nxt = lowest_set(key_state);
          end else if (HAS_SUSTAIN) begin
            state_nxt = RELEASE;
            sus_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RELEASE: begin
        // A new press outranks the sustain timeout.
        if (any_key) begin
          state_nxt = PLAY;
          key_nxt   = lowest_set(key_state);
          sus_nxt   = '0;
        end else if (sus_cnt == SUS_LAST) begin
          state_nxt = IDLE;
          sus_nxt   = '0;
        end else begin
          sus_nxt = sus_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      active_key <= '0;
      sus_cnt    <= '0;
      busy       <= 1'b0;
      speaker    <= 1'b0;
    end else begin
      state      <= state_nxt;
      active_key <= key_nxt;
      sus_cnt    <= sus_nxt;
      busy       <= (state_nxt != IDLE);
      // Routed from the registered active_key: on a new selection the
      // speaker tracks the new note one clock after the FSM latches it.
      speaker    <= (state_nxt != IDLE) ? bus.note_in[active_key] : 1'b0;
    end
  end

  assign bus.speaker    = speaker;
  assign bus.busy       = busy;
  assign bus.active_key = active_key;
  assign bus.key_state  = key_state;

endmodule

// File: tb/tb_piano_voice_select.sv
// tb_piano_voice_select
//   Drives two instances (sustain 10 and sustain 0) with the same keys
//   and note waves. A behavioural model of the key filter and voice
//   policy predicts every output each cycle; directed steps exercise
//   the debounce, priority, retrigger, sustain, abort and reset cases,
//   followed by a random key-toggling phase.
module tb_piano_voice_select;

  localparam int NK  = 8;
  localparam int DEB = 4;
  localparam int SUS = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] keys = '0;
  logic [NK-1:0] note_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piano_voice_select_if #(.NUM_KEYS(NK)) if_s ();
  piano_voice_select_if #(.NUM_KEYS(NK)) if_z ();

  assign if_s.keys    = keys;
  assign if_s.note_in = note_in;
  assign if_z.keys    = keys;
  assign if_z.note_in = note_in;

  piano_voice_select #(.NUM_KEYS(NK), .DEB_CYCLES(DEB), .SUSTAIN_CYCLES(SUS)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s.slave)
  );

  piano_voice_select #(.NUM_KEYS(NK), .DEB_CYCLES(DEB), .SUSTAIN_CYCLES(0)) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (if_z.slave)
  );

  // ---------------- behavioural model ----------------
  // Key filter: a key's accepted level flips once the synchronised level
  // has disagreed with it for DEB samples in a row.
  logic [NK-1:0] m_s1, m_s2, m_deb;
  int            m_run [NK];
  // Voice: mode 0 silent, 1 key held, 2 sustain tail with v_tail clocks left.
  int            v_mode [2];
  int            v_idx  [2];
  int            v_tail [2];
  logic          v_spk  [2];
  int            sus_len [2] = '{SUS, 0};
  int            ph [NK];

  function automatic int lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
    for (int c = 0; c < 2; c++) begin
      v_mode[c] = 0; v_idx[c] = 0; v_tail[c] = 0; v_spk[c] = 1'b0;
    end
  endtask

  task automatic model_clock();
    logic [NK-1:0] old_deb;
    int lo, old_idx;
    old_deb = m_deb;
    for (int i = 0; i < NK; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = keys;
    lo = lowest(old_deb);
    for (int c = 0; c < 2; c++) begin
      old_idx = v_idx[c];
      case (v_mode[c])
        0: if (lo >= 0) begin v_mode[c] = 1; v_idx[c] = lo; end
        1: if (!old_deb[v_idx[c]]) begin
             if (lo >= 0) v_idx[c] = lo;
             else if (sus_len[c] > 0) begin v_mode[c] = 2; v_tail[c] = sus_len[c]; end
             else v_mode[c] = 0;
           end
        default: if (lo >= 0) begin
             v_mode[c] = 1; v_idx[c] = lo;
           end else begin
             v_tail[c]--;
             if (v_tail[c] == 0) v_mode[c] = 0;
           end
      endcase
      v_spk[c] = (v_mode[c] != 0) ? note_in[old_idx] : 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("s.speaker",    32'(if_s.speaker),    32'(v_spk[0]));
    check("s.busy",       32'(if_s.busy),       32'(v_mode[0] != 0));
    check("s.active_key", 32'(if_s.active_key), 32'(v_idx[0]));
    check("s.key_state",  32'(if_s.key_state),  32'(m_deb));
    check("z.speaker",    32'(if_z.speaker),    32'(v_spk[1]));
    check("z.busy",       32'(if_z.busy),       32'(v_mode[1] != 0));
    check("z.active_key", 32'(if_z.active_key), 32'(v_idx[1]));
    check("z.key_state",  32'(if_z.key_state),  32'(m_deb));
  endtask

  // One clock: model follows the edge, outputs checked on the falling
  // edge, then the note waves advance (note i toggles every i+2 clocks).
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_clock();
    @(negedge clk);
    check_all();
    for (int i = 0; i < NK; i++) begin
      ph[i]++;
      if (ph[i] == i + 2) begin
        note_in[i] = ~note_in[i];
        ph[i] = 0;
      end
    end
  endtask

  initial begin
    int ns, nz, k;
    logic nbit;
    int bseq [12] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < NK; i++) ph[i] = 0;
    model_reset();
    repeat (2) step();
    check("reset speaker", 32'(if_s.speaker), 32'd0);
    check("reset busy", 32'(if_s.busy), 32'd0);
    check("reset active_key", 32'(if_s.active_key), 32'd0);
    reset = 1'b0;
    repeat (3) step();

    // 1: clean press of key 3
    keys[3] = 1'b1;
    repeat (5) step();
    check("t1 key_state3 before 6", 32'(if_s.key_state[3]), 32'd0);
    step();
    check("t1 key_state3 at 6", 32'(if_s.key_state[3]), 32'd1);
    check("t1 busy at 6", 32'(if_s.busy), 32'd0);
    step();
    check("t1 busy at 7", 32'(if_s.busy), 32'd1);
    check("t1 active_key", 32'(if_s.active_key), 32'd3);
    for (int j = 0; j < 12; j++) begin
      nbit = note_in[3];
      step();
      check("t1 speaker follows note3", 32'(if_s.speaker), 32'(nbit));
    end
    keys = '0;
    repeat (30) step();
    check("t1 idle after release", 32'(if_s.busy), 32'd0);

    // 2: bouncing key 5 never accepted
    for (int j = 0; j < 12; j++) begin
      keys[5] = bseq[j][0];
      step();
      check("t2 key_state5", 32'(if_s.key_state[5]), 32'd0);
      check("t2 busy", 32'(if_s.busy), 32'd0);
      check("t2 speaker", 32'(if_s.speaker), 32'd0);
    end
    repeat (4) step();

    // 3: simultaneous 6 and 2, then retrigger to 6
    keys[6] = 1'b1; keys[2] = 1'b1;
    repeat (7) step();
    check("t3 active_key 2", 32'(if_s.active_key), 32'd2);
    keys[2] = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("t3 busy held", 32'(if_s.busy), 32'd1);
      check("t3 still 2", 32'(if_s.active_key), 32'd2);
    end
    step();
    check("t3 retrigger to 6", 32'(if_s.active_key), 32'd6);
    check("t3 busy after retrigger", 32'(if_s.busy), 32'd1);
    check("t3 zero-sustain retrigger", 32'(if_z.active_key), 32'd6);
    keys = '0;
    repeat (30) step();

    // 4: key 1 alone, sustain tail of exactly SUS clocks
    keys[1] = 1'b1;
    repeat (10) step();
    check("t4 active_key 1", 32'(if_s.active_key), 32'd1);
    keys[1] = 1'b0;
    k = 0;
    while (if_s.key_state[1] && k < 20) begin step(); k++; end
    check("t4 key_state1 fell", 32'(if_s.key_state[1]), 32'd0);
    ns = 0; nz = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      if (if_s.busy) ns++;
      if (if_z.busy) nz++;
    end
    check("t4 sustain length", 32'(ns), 32'(SUS));
    check("t4 zero-sustain length", 32'(nz), 32'd0);
    check("t4 speaker off", 32'(if_s.speaker), 32'd0);

    // 5: key 4 debounced at sustain count 5 aborts the tail
    keys[1] = 1'b1;
    repeat (10) step();
    keys[1] = 1'b0;
    repeat (6) step();
    keys[4] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      step();
      check("t5 busy held", 32'(if_s.busy), 32'd1);
    end
    check("t5 active_key 4", 32'(if_s.active_key), 32'd4);
    keys = '0;
    repeat (30) step();

    // 6: reset mid-note with key 7 held
    keys[7] = 1'b1;
    repeat (9) step();
    check("t6 playing 7", 32'(if_s.active_key), 32'd7);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("t6 async speaker", 32'(if_s.speaker), 32'd0);
    check("t6 async busy", 32'(if_s.busy), 32'd0);
    check("t6 async key_state", 32'(if_s.key_state), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    repeat (6) step();
    check("t6 busy before 7", 32'(if_s.busy), 32'd0);
    step();
    check("t6 busy at 7", 32'(if_s.busy), 32'd1);
    check("t6 active_key 7", 32'(if_s.active_key), 32'd7);
    nbit = note_in[7];
    step();
    check("t6 sound at 8", 32'(if_s.speaker), 32'(nbit));
    keys[7] = 1'b0;
    k = 0;
    while (if_z.key_state[7] && k < 20) begin step(); k++; end
    check("t6 key_state7 fell", 32'(if_z.key_state[7]), 32'd0);
    step();
    check("t6 zero-sustain speaker off", 32'(if_z.speaker), 32'd0);
    check("t6 zero-sustain idle", 32'(if_z.busy), 32'd0);
    repeat (20) step();

    // random key activity
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
      step();
    end
    keys = '0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
